// File: rtl/piso_tx_sched.sv
// piso_tx_sched: one round-robin arbitrated parallel-in/serial-out transmitter.
// Several producers present DW-bit words. One word is granted at a time,
// captured, and shifted out MSB-first, with each bit held for DIV clocks.
// Frame timing: IDLE (arbitrate) -> SHIFT (DW*DIV cycles) -> GAP (1 cycle).
//
// Handshake: a requester raises req[i] (a level) and holds req[i] and its
// din slice stable until ack[i] pulses. The ack pulse comes in the same cycle
// as the first serial bit. din is captured at the grant edge, so later changes
// are ignored. A req still high after ack counts as a new request.
// req is sampled only while the FSM is in IDLE.
//
// All outputs are registered. state_dbg exposes the FSM state
// (0=IDLE, 1=SHIFT, 2=GAP).
module piso_tx_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int DIV  = 2,
  parameter int IW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  output logic [NREQ-1:0]      ack,
  output logic [IW-1:0]        src_id,
  output logic                 busy,
  output logic                 dout,
  output logic                 dout_vld,
  output logic                 frame_done,
  output logic [1:0]           state_dbg
);

  localparam int IXW = (DW > 1) ? $clog2(DW) : 1;
  localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e          state_q;
  logic [DW-1:0]   shreg_q;
  logic [IXW-1:0]  idx_q;
  logic [DVW-1:0]  div_q;
  logic [IW-1:0]   last_q;
  logic [NREQ-1:0] ack_q;
  logic [IW-1:0]   src_q;
  logic            busy_q;
  logic            dout_q;
  logic            vld_q;
  logic            fd_q;

  // Arbiter candidates: the lowest set requester above the pointer, and the lowest one at or below it
  logic            hit_hi;
  logic            hit_lo;
  logic [IW-1:0]   win_hi;
  logic [IW-1:0]   win_lo;
  logic [DW-1:0]   word_hi;
  logic [DW-1:0]   word_lo;
  logic [IW-1:0]   grant_d;
  logic [DW-1:0]   word_d;
  logic [NREQ-1:0] ack_d;
  logic            div_last;

  // Round-robin search: the loop runs downward, so the last match is the lowest index in each half
  always_comb begin
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    win_hi  = '0;
    win_lo  = '0;
    word_hi = '0;
    word_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(last_q)) begin
          hit_hi  = 1'b1;
          win_hi  = IW'(i);
          word_hi = din[i*DW +: DW];
        end else begin
          hit_lo  = 1'b1;
          win_lo  = IW'(i);
          word_lo = din[i*DW +: DW];
        end
      end
    end
  end

  assign grant_d  = hit_hi ? win_hi : win_lo;
  assign word_d   = hit_hi ? word_hi : word_lo;
  assign ack_d    = {{(NREQ-1){1'b0}}, 1'b1} << grant_d;
  assign div_last = (div_q == DVW'(DIV - 1));

  // Single FSM: the grant, the bit/divider counters and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= IXW'(DW - 1);
      div_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      ack_q   <= '0;
      src_q   <= '0;
      busy_q  <= 1'b0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q <= ST_SHIFT;
            shreg_q <= word_d;
            last_q  <= grant_d;
            src_q   <= grant_d;
            ack_q   <= ack_d;
            idx_q   <= IXW'(DW - 1);
            div_q   <= '0;
            busy_q  <= 1'b1;
            dout_q  <= word_d[DW-1];
            vld_q   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (div_last) begin
            if (idx_q == '0) begin
              state_q <= ST_GAP;
              fd_q    <= 1'b1;
              dout_q  <= 1'b0;
              vld_q   <= 1'b0;
            end else begin
              idx_q  <= idx_q - 1'b1;
              div_q  <= '0;
              dout_q <= shreg_q[idx_q - 1'b1];
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
          fd_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          fd_q    <= 1'b0;
          busy_q  <= 1'b0;
          dout_q  <= 1'b0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign src_id     = src_q;
  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_vld   = vld_q;
  assign frame_done = fd_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Testbench for piso_tx_sched. Two instances are used: DIV=2 (main) and DIV=1 (edge case).
// Expected frames {src_id, word} are queued when a request is driven. A monitor
// on the falling edge checks the ack pulses, the bit hold, and the reassembled
// frame against the queue.
module tb_piso_tx_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;
  localparam int W    = IW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  logic [NREQ-1:0]    req0, req1;
  logic [NREQ*DW-1:0] din0, din1;
  logic [NREQ-1:0]    ack0, ack1;
  logic [IW-1:0]      src0, src1;
  logic               busy0, busy1, dout0, dout1, vld0, vld1, fd0, fd1;
  logic [1:0]         st0, st1;

  piso_tx_sched #(.NREQ(NREQ), .DW(DW), .DIV(2), .IW(IW)) u_dut (
    .clk(clk), .rst(rst), .req(req0), .din(din0), .ack(ack0), .src_id(src0),
    .busy(busy0), .dout(dout0), .dout_vld(vld0), .frame_done(fd0), .state_dbg(st0)
  );

  piso_tx_sched #(.NREQ(NREQ), .DW(DW), .DIV(1), .IW(IW)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .din(din1), .ack(ack1), .src_id(src1),
    .busy(busy1), .dout(dout1), .dout_vld(vld1), .frame_done(fd1), .state_dbg(st1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [W-1:0] ent(input int s, input logic [DW-1:0] w);
    return {IW'(s), w};
  endfunction

  // Monitor: compares what each DUT presents against the front of its queue
  initial begin
    int vcnt [2];
    logic [DW-1:0] wacc [2];
    logic lastb [2];
    logic [NREQ-1:0] a, ea;
    logic [IW-1:0] s;
    logic v, d, f, have;
    int dv;
    logic [W-1:0] e;
    for (int u = 0; u < 2; u++) begin
      vcnt[u] = 0; wacc[u] = '0; lastb[u] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int u = 0; u < 2; u++) begin
          vcnt[u] = 0; wacc[u] = '0; lastb[u] = 1'b0;
        end
      end else begin
        for (int u = 0; u < 2; u++) begin
          a  = (u == 1) ? ack1 : ack0;
          s  = (u == 1) ? src1 : src0;
          v  = (u == 1) ? vld1 : vld0;
          d  = (u == 1) ? dout1 : dout0;
          f  = (u == 1) ? fd1 : fd0;
          dv = (u == 1) ? 1 : 2;
          have = (u == 1) ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
          e = '0;
          if (have) e = (u == 1) ? exp_q1[0] : exp_q0[0];
          ea = 4'b0001 << e[W-1:DW];
          if (a != '0) begin
            if (have) begin
              check("mon_ack", {a, s}, {ea, e[W-1:DW]});
              check("mon_ack_first_bit", {v, vcnt[u] == 0}, 2'b11);
            end else begin
              check("mon_ack_unexpected", a, 0);
            end
          end
          if (v) begin
            if (vcnt[u] % dv == 0) wacc[u] = {wacc[u][DW-2:0], d};
            else check("mon_bit_hold", d, lastb[u]);
            lastb[u] = d;
            vcnt[u]++;
          end else begin
            check("mon_dout_idle_zero", d, 0);
          end
          if (f) begin
            if (have) begin
              check("mon_frame_len", vcnt[u], DW * dv);
              check("mon_frame_word", {s, wacc[u]}, e);
              if (u == 1) void'(exp_q1.pop_front());
              else void'(exp_q0.pop_front());
            end else begin
              check("mon_fd_unexpected", f, 0);
            end
            vcnt[u] = 0;
            wacc[u] = '0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input int u, output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((u == 1) ? ack1 : ack0) == '0 && n < 100);
    check("ack_wait", ((u == 1) ? ack1 : ack0) != '0, 1);
    at = cyc;
  endtask

  task automatic wait_fd(input int u, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((u == 1) ? fd1 : fd0) == 1'b0 && n < 100);
    check("fd_wait", (u == 1) ? fd1 : fd0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_prev, t_now, n, seen;
    int exp_src [5];
    req0 = '0;
    req1 = '0;
    din0 = {8'h44, 8'h33, 8'h22, 8'hA5};
    din1 = {8'h00, 8'h00, 8'h00, 8'h81};
    t_prev = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_outs0", {ack0, src0, busy0, dout0, vld0, fd0, st0}, 0);
    check("reset_outs1", {ack1, src1, busy1, dout1, vld1, fd1, st1}, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("idle_after_release", {busy0, vld0, st0}, 0);

    // Single word 0xA5 from requester 0: 16 valid cycles, then the GAP cycle, then IDLE
    @(posedge clk); #1 req0 = 4'b0001;
    exp_q0.push_back(ent(0, 8'hA5));
    wait_ack(0, t_now);
    check("t1_ack", ack0, 4'b0001);
    check("t1_src", src0, 0);
    req0 = '0;
    wait_fd(0, n);
    check("t1_fd_latency", n, 16);
    check("t1_gap_outs", {busy0, vld0, dout0, st0}, {1'b1, 1'b0, 1'b0, 2'd2});
    @(negedge clk);
    check("t1_idle", {busy0, fd0, st0}, 0);

    // Round-robin fairness from a fresh pointer: 0,1,2,3,0 with acks 18 cycles apart
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    req0 = 4'b1111;
    exp_src = '{0, 1, 2, 3, 0};
    exp_q0.push_back(ent(0, 8'hA5));
    exp_q0.push_back(ent(1, 8'h22));
    exp_q0.push_back(ent(2, 8'h33));
    exp_q0.push_back(ent(3, 8'h44));
    exp_q0.push_back(ent(0, 8'hA5));
    for (int k = 0; k < 5; k++) begin
      wait_ack(0, t_now);
      check("t2_grant_order", src0, exp_src[k]);
      if (k > 0) check("t2_ack_spacing", t_now - t_prev, 18);
      t_prev = t_now;
    end
    req0 = '0;
    wait_fd(0, n);
    check("t2_fd_latency", n, 16);

    // Pointer rotation: the pointer is at 0; requesters 1 and 3 give the order 1,3,1
    req0 = 4'b1010;
    exp_q0.push_back(ent(1, 8'h22));
    exp_q0.push_back(ent(3, 8'h44));
    exp_q0.push_back(ent(1, 8'h22));
    exp_src = '{1, 3, 1, 0, 0};
    for (int k = 0; k < 3; k++) begin
      wait_ack(0, t_now);
      check("t3_rotation", src0, exp_src[k]);
    end
    req0 = '0;
    wait_fd(0, n);

    // DIV=1: 0x81 shifts out in 8 consecutive cycles, and frame_done follows
    req1 = 4'b0001;
    exp_q1.push_back(ent(0, 8'h81));
    wait_ack(1, t_now);
    check("t4_ack", ack1, 4'b0001);
    req1 = '0;
    wait_fd(1, n);
    check("t4_fd_latency", n, 8);
    @(negedge clk);
    check("t4_idle", st1, 0);

    // Reset during the 4th bit of 0x33 (bit 4 = 1): outputs clear at once, then requester 0 is granted
    req0 = 4'b0100;
    exp_q0.push_back(ent(2, 8'h33));
    wait_ack(0, t_now);
    check("t5_src", src0, 2);
    req0 = '0;
    repeat (6) @(negedge clk);
    check("t5_bit4", {vld0, dout0}, 2'b11);
    #1 rst = 1'b0;
    exp_q0.delete();
    #1 check("t5_abort_outs", {ack0, src0, busy0, dout0, vld0, fd0, st0}, 0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (fd0 || ack0 != '0 || st0 != 2'd0) seen++;
    end
    check("t5_no_fd_after_abort", seen, 0);
    req0 = 4'b1111;
    exp_q0.push_back(ent(0, 8'hA5));
    wait_ack(0, t_now);
    check("t5_regrant_0", src0, 0);
    req0 = '0;
    wait_fd(0, n);

    // Request withdrawn while busy: req[2] pulses during SHIFT and is never acked
    req0 = 4'b1000;
    exp_q0.push_back(ent(3, 8'h44));
    wait_ack(0, t_now);
    check("t6_src", src0, 3);
    req0 = '0;
    repeat (4) @(negedge clk);
    req0 = 4'b0100;
    repeat (3) @(negedge clk);
    req0 = '0;
    wait_fd(0, n);
    check("t6_fd_latency", n, 9);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (st0 != 2'd0 || ack0 != '0) seen++;
    end
    check("t6_stays_idle", seen, 0);

    // ---------------- final report ----------------
    repeat (3) @(negedge clk);
    check("queue0_drained", exp_q0.size(), 0);
    check("queue1_drained", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx_sched.md
Name: piso_tx_sched

Overview:
- Shared parallel-in/serial-out transmit engine with a built-in request scheduler.
- Several producers each present a DW-bit word. A round-robin arbiter picks one, loads the word, and shifts it out MSB-first at a programmable clocks-per-bit rate.
- Sits between the parallel datapath sources and a single serial line. Replaces per-source PISO instances with one arbitrated serializer.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, word width in bits (>=2)
- DIV, 2, clock cycles each serial bit is held (>=1)
- IW, 2, width of requester index; must equal ceil(log2(NREQ))

Ports:
- clk, in, 1, single clock; all state updates on posedge
- rst, in, 1, asynchronous reset, active-low; state is cleared while rst==0
- req, in, NREQ, per-requester transmit request (level)
- din, in, NREQ*DW, packed words; requester i occupies bits [i*DW+DW-1 : i*DW]
- ack, out, NREQ, one-cycle pulse on bit i when requester i's word is captured
- src_id, out, IW, index of the requester currently being serialized
- busy, out, 1, high from first shift cycle through the gap cycle
- dout, out, 1, serial data
- dout_vld, out, 1, high while dout carries a valid bit
- frame_done, out, 1, one-cycle pulse after the last bit of a frame

Behaviour:
- Reset (rst==0, asynchronous): all outputs, state, and counters take these values:
  - state=IDLE; ack=0, src_id=0, busy=0, dout=0, dout_vld=0, frame_done=0
  - shift register=0, bit index=DW-1, divider=0
  - round-robin pointer last=NREQ-1, so requester 0 has first priority
- All outputs are registered.
- FSM has three states: IDLE, SHIFT, GAP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, search from (last+1) mod NREQ upward with wrap. The first set bit wins (winner w).
  - At the next edge:
    - shreg<=din[w]; last<=w; src_id<=w
    - ack[w]<=1, all other ack bits 0
    - bit index<=DW-1, divider<=0; state<=SHIFT
- SHIFT:
  - dout=shreg[index]; dout_vld=1; busy=1.
  - Divider counts 0..DIV-1. When divider==DIV-1:
    - If index==0: state<=GAP and frame_done<=1.
    - Otherwise: index<=index-1 and divider<=0.
  - Each bit is held exactly DIV cycles; the frame occupies DW*DIV SHIFT cycles.
  - ack is high only in the first SHIFT cycle.
- GAP:
  - Lasts one cycle. dout=0, dout_vld=0, busy=1, frame_done=1.
  - Always returns to IDLE; no arbitration takes place in GAP.
- Throughput: back-to-back frames repeat every DW*DIV+2 cycles (IDLE + SHIFT + GAP).
- Requester contract: hold req and din stable until ack.
  - din changes after ack are ignored, because the word is already captured.
  - If req is still high after ack, it counts as a new request for the next arbitration.
- req deasserted before being granted: it is not serviced and produces no ack.
- req is sampled only in IDLE; requests arriving in SHIFT/GAP wait.
- src_id holds its value from grant until the next grant.
- DIV=1: one cycle per bit; no divider stall.
- Reset mid-frame: immediate abort. No frame_done and no further ack. The pointer returns to NREQ-1.
- dout is never X: it is 0 whenever dout_vld==0.

Test Plan:
- Single word, reset released, DIV=2, DW=8:
  - Stimulus: req=0001, din0=0xA5, req sampled in IDLE at cycle 0.
  - Response: ack[0]=1 at cycle 1; dout=1,0,1,0,0,1,0,1, each bit for 2 cycles, cycles 1..16 with dout_vld=1; frame_done=1 and dout_vld=0 at cycle 17; IDLE at cycle 18.
- Round-robin fairness:
  - Stimulus: req=1111 held continuously.
  - Response: grant order src_id=0,1,2,3,0; ack pulses spaced 18 cycles apart.
- Pointer rotation:
  - Stimulus: after requester 1 is granted, only req[1] and req[3] remain high.
  - Response: next grant is 3, then 1.
- Parameter edge, DIV=1:
  - Stimulus: DIV=1, din=0x81.
  - Response: dout=1,0,0,0,0,0,0,1 over 8 consecutive cycles; frame_done one cycle later.
- Reset mid-frame:
  - Stimulus: rst driven low during the 4th bit.
  - Response: same cycle, dout=0, dout_vld=0, busy=0, no frame_done. After release, a request with req=1111 grants requester 0.
- Request withdrawn while busy:
  - Stimulus: req[2] pulses high for 3 cycles during SHIFT, then drops.
  - Response: ack[2] never asserts; FSM stays in IDLE after GAP.
